// File: rtl/adder_pkg.sv
// Shared constants, operand packet layout and scheduler state encoding for the
// byte-sum adder and its round-robin front end.
package adder_pkg;

  localparam int INS_W  = 65;
  localparam int SUM_W  = 10;
  localparam int BYTE_W = 8;

  localparam int S1_X_LSB = 0;
  localparam int S1_Y_LSB = 8;
  localparam int S1_Z_LSB = 16;
  localparam int S1_W_LSB = 24;
  localparam int CIN_BIT  = 32;
  localparam int S2_X_LSB = 33;
  localparam int S2_Y_LSB = 41;
  localparam int S2_Z_LSB = 49;
  localparam int S2_W_LSB = 57;

  typedef struct packed {
    logic [BYTE_W-1:0] w;
    logic [BYTE_W-1:0] z;
    logic [BYTE_W-1:0] y;
    logic [BYTE_W-1:0] x;
  } rec_t;

  // Field order matches the bit offsets above: s1 in the low word, s2 on top.
  typedef struct packed {
    rec_t s2;
    logic cin;
    rec_t s1;
  } ins_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Round-robin arbiter: lowest-index valid request at or above ptr, wrapping at N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam int SW = IW + 1;

  always_comb begin
    logic [SW-1:0] pos;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      idx = pos[IW-1:0];
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Shares one registered byte-sum adder between NREQ requesters; each accepted
// packet is answered three cycles later on a tagged valid/ready response port.
module adder_sched
  import adder_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*INS_W-1:0]   req_ins,
  output logic [NREQ-1:0]         req_ready,
  output logic [INS_W-1:0]        add_ins,
  input  logic [SUM_W-1:0]        add_sm_r,
  input  logic                    add_sm_zero_r,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [SUM_W-1:0]        rsp_sum,
  output logic                    rsp_zero,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_cnt
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] CALC = 2'(ST_CALC);
  localparam logic [1:0] WAIT = 2'(ST_WAIT);
  localparam logic [1:0] RESP = 2'(ST_RESP);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  ptr_nxt;
  logic             gnt_any;
  logic             arb_en;
  logic [INS_W-1:0] sel_ins;

  // Grants only happen when the response slot is free or being freed this cycle.
  assign arb_en = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));

  rr_arbiter #(
    .N  (NREQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  always_comb begin
    sel_ins = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == ID_W'(k)) sel_ins = req_ins[k*INS_W +: INS_W];
    end
  end

  assign ptr_nxt = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      add_ins   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_zero  <= 1'b0;
      op_cnt    <= '0;
    end else begin
      // gnt_any is only ever set in IDLE or in RESP while the response retires.
      if (gnt_any) begin
        add_ins <= sel_ins;
        id_q    <= gnt_idx;
        ptr     <= ptr_nxt;
      end
      case (state)
        IDLE: if (gnt_any) state <= CALC;
        CALC: state <= WAIT;
        WAIT: begin
          rsp_sum   <= add_sm_r;
          rsp_zero  <= add_sm_zero_r;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_cnt    <= op_cnt + CNT_W'(1);
            state     <= gnt_any ? CALC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Randomized and directed bench for adder_sched with a transaction-level
// reference model and a behavioural registered adder.
module tb_adder_sched;
  import adder_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*65-1:0]   req_ins;
  logic [N-1:0]      req_ready;
  logic [64:0]       add_ins;
  logic [9:0]        add_sm_r;
  logic              add_sm_zero_r;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [9:0]        rsp_sum;
  logic              rsp_zero;
  logic              rsp_ready;
  logic              busy;
  logic [CW-1:0]     op_cnt;

  logic [64:0] pkt [N];

  always_comb begin
    for (int k = 0; k < N; k++) req_ins[65*k +: 65] = pkt[k];
  end

  adder_sched #(.NREQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ins       (req_ins),
    .req_ready     (req_ready),
    .add_ins       (add_ins),
    .add_sm_r      (add_sm_r),
    .add_sm_zero_r (add_sm_zero_r),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_sum       (rsp_sum),
    .rsp_zero      (rsp_zero),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .op_cnt        (op_cnt)
  );

  function automatic logic [9:0] bsum(input logic [64:0] p);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(p[8*k +: 8]);
    s += int'(p[32]);
    for (int k = 0; k < 4; k++) s += int'(p[33 + 8*k +: 8]);
    return 10'(s);
  endfunction

  function automatic logic [64:0] mk(input logic [31:0] s1, input logic cin, input logic [31:0] s2);
    return {s2, cin, s1};
  endfunction

  function automatic logic [64:0] rnd_pkt();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  // Behavioural adder: registered byte-sum with active-low reset from ~rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_sm_r      <= '0;
      add_sm_zero_r <= 1'b0;
    end else begin
      add_sm_r      <= bsum(add_ins);
      add_sm_zero_r <= (bsum(add_ins) == 10'd0);
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding operation, response visible on
  // the third cycle after the accept cycle, round-robin pointer after grant.
  bit          m_on   = 1'b0;
  bit          m_busy = 1'b0;
  int          m_left = 0;
  int          m_ptr  = 0;
  int          m_cnt  = 0;
  int          m_id   = 0;
  logic [64:0] m_pkt  = '0;
  logic [9:0]  m_sum  = '0;
  int          acc_id = -1;
  int          cyc    = 0;

  task automatic monitor();
    bit           allowed;
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy;
    bit           rv;
    g      = -1;
    acc_id = -1;
    if (m_on) begin
      allowed = !rst && (!m_busy || (m_left == 0 && rsp_ready));
      if (allowed) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      rv = m_busy && (m_left == 0);
      check("req_ready", 65'(req_ready), 65'(exp_rdy));
      check("busy", 65'(busy), 65'(m_busy));
      check("rsp_valid", 65'(rsp_valid), 65'(rv));
      check("op_cnt", 65'(op_cnt), 65'(m_cnt % 16));
      if (rv) begin
        check("rsp_id", 65'(rsp_id), 65'(m_id));
        check("rsp_sum", 65'(rsp_sum), 65'(m_sum));
        check("rsp_zero", 65'(rsp_zero), 65'(m_sum == 10'd0));
      end
      if (m_busy && m_left == 2) check("add_ins", add_ins, m_pkt);
    end
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_left = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_on) begin
      if (m_busy) begin
        if (m_left > 0) m_left--;
        else if (rsp_ready) begin m_busy = 1'b0; m_cnt++; end
      end
      if (g >= 0) begin
        m_busy = 1'b1; m_left = 2; m_ptr = (g + 1) % N; m_id = g;
        m_pkt = pkt[g]; m_sum = bsum(pkt[g]); acc_id = g;
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic one_op(input int i, input logic [64:0] p,
                        output logic [9:0] s, output logic z, output logic [IW-1:0] id);
    int n;
    pkt[i] = p; req_valid[i] = 1'b1; rsp_ready = 1'b1; acc_id = -1; n = 0;
    while (acc_id != i && n < 20) begin tick(); n++; end
    check("accept_timeout", 65'(acc_id == i), 65'(1));
    req_valid[i] = 1'b0; n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("rsp_timeout", 65'(rsp_valid), 65'(1));
    s = rsp_sum; z = rsp_zero; id = rsp_id;
    tick();
  endtask

  initial begin
    logic [9:0]    s;
    logic          z;
    logic [IW-1:0] id;
    int            order [5];
    int            at [5];
    int            ng;
    int            n;
    logic [9:0]    hs;
    logic [IW-1:0] hid;

    for (int k = 0; k < N; k++) pkt[k] = '0;
    do_reset();
    tick();
    check("rst_add_ins", add_ins, 65'(0));
    check("rst_rsp_valid", 65'(rsp_valid), 65'(0));
    check("rst_rsp_id", 65'(rsp_id), 65'(0));
    check("rst_rsp_sum", 65'(rsp_sum), 65'(0));
    check("rst_rsp_zero", 65'(rsp_zero), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_op_cnt", 65'(op_cnt), 65'(0));

    // Single request from requester 2.
    pkt[2] = mk(32'h01020304, 1'b1, 32'h05060708);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 65'(req_ready), 65'(4'b0100));
    tick();
    req_valid = '0;
    tick(); tick();
    check("single_valid", 65'(rsp_valid), 65'(1));
    check("single_id", 65'(rsp_id), 65'(2));
    check("single_sum", 65'(rsp_sum), 65'(37));
    check("single_zero", 65'(rsp_zero), 65'(0));
    tick();
    check("single_cnt", 65'(op_cnt), 65'(1));

    one_op(0, {65{1'b1}}, s, z, id);
    check("ovf_sum", 65'(s), 65'(1017));
    check("ovf_zero", 65'(z), 65'(0));
    one_op(1, 65'(0), s, z, id);
    check("zero_sum", 65'(s), 65'(0));
    check("zero_flag", 65'(z), 65'(1));

    // Round robin with all requesters continuously valid.
    do_reset();
    for (int k = 0; k < N; k++) pkt[k] = rnd_pkt();
    req_valid = 4'hF; ng = 0; n = 0;
    while (ng < 5 && n < 40) begin
      tick(); n++;
      if (acc_id >= 0) begin
        order[ng] = acc_id; at[ng] = cyc; ng++;
        pkt[acc_id] = rnd_pkt();
      end
    end
    check("rr_count", 65'(ng), 65'(5));
    for (int k = 0; k < 5; k++) check("rr_order", 65'(order[k]), 65'(k % N));
    for (int k = 1; k < 5; k++) check("rr_gap", 65'(at[k] - at[k-1]), 65'(3));
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();

    // Backpressure while requesters 1 and 3 wait.
    do_reset();
    pkt[0] = rnd_pkt(); req_valid = 4'b0001; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b1010; pkt[1] = rnd_pkt(); pkt[3] = rnd_pkt();
    tick(); tick();
    hs = rsp_sum; hid = rsp_id;
    check("bp_hid", 65'(hid), 65'(0));
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready_low", 65'(req_ready), 65'(0));
      check("bp_sum_hold", 65'(rsp_sum), 65'(hs));
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_next_grant", 65'(req_ready), 65'(4'b0010));
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();

    // Reset while an operation is in WAIT.
    do_reset();
    one_op(0, rnd_pkt(), s, z, id);
    pkt[2] = rnd_pkt(); req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1; req_valid = 4'hF;
    for (int k = 0; k < N; k++) pkt[k] = rnd_pkt();
    tick();
    check("mid_rst_valid", 65'(rsp_valid), 65'(0));
    check("mid_rst_busy", 65'(busy), 65'(0));
    check("mid_rst_cnt", 65'(op_cnt), 65'(0));
    rst = 1'b0;
    #1;
    check("mid_rst_grant", 65'(req_ready), 65'(4'b0001));
    tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();

    // Counter wrap at CNT_W = 4.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      pkt[k % N] = rnd_pkt();
      one_op(k % N, pkt[k % N], s, z, id);
      check("wrap_sum", 65'(s), 65'(bsum(pkt[k % N])));
    end
    check("wrap_cnt", 65'(op_cnt), 65'(1));

    // Random traffic with backpressure, drops and occasional reset.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            pkt[k] = ($urandom_range(0, 15) == 0) ? 65'(0) : rnd_pkt();
            req_valid[k] = 1'b1;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      tick();
      if (acc_id >= 0) req_valid[acc_id] = 1'(($urandom_range(0, 1)));
    end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
